alu_sequencer: RTL and testbench

- Control stage directly upstream of the 6-bit signed ALU.
- Accepts 16-bit instructions over a valid/ready handshake and holds a small 6-bit register file.
- Drives the ALU operand/opcode/immediate inputs from registered values, then writes the ALU result back and latches the ALU flags.
- Also provides register load-immediate and a register-output port with its own valid/ready handshake. One instruction is in flight at a time.

---
 rtl/alu_sequencer_pkg.sv | 56 +++++
 rtl/alu_sequencer_regfile.sv | 39 +++
 rtl/alu_sequencer.sv | 177 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// alu_sequencer_pkg
// Shared definitions for the ALU control sequencer: datapath widths, opcode
// map, ALU flag bit positions, instruction field positions and the FSM state
// encoding.
// ----------------------------------------------------------------------------
package alu_sequencer_pkg;

    localparam int DATA_W  = 6;
    localparam int REG_CNT = 4;
    localparam int ADDR_W  = 2;
    localparam int INSTR_W = 16;
    localparam int OPER_W  = 3;
    localparam int FLAG_W  = 4;

    // Opcode map. 000..101 are executed by the ALU.
    localparam logic [OPER_W-1:0] OP_ADD   = 3'b000;
    localparam logic [OPER_W-1:0] OP_SUB   = 3'b001;
    localparam logic [OPER_W-1:0] OP_SHIFT = 3'b010;
    localparam logic [OPER_W-1:0] OP_AND   = 3'b011;
    localparam logic [OPER_W-1:0] OP_OR    = 3'b100;
    localparam logic [OPER_W-1:0] OP_XOR   = 3'b101;
    localparam logic [OPER_W-1:0] OP_LOAD  = 3'b110;
    localparam logic [OPER_W-1:0] OP_OUT   = 3'b111;

    // ALU flag bit indices.
    localparam int FLAG_NEG  = 0;
    localparam int FLAG_POS  = 1;
    localparam int FLAG_ZERO = 2;
    localparam int FLAG_OVF  = 3;

    // Instruction field positions.
    localparam int F_OPER_HI = 15;
    localparam int F_OPER_LO = 13;
    localparam int F_IMM     = 12;
    localparam int F_DST_HI  = 11;
    localparam int F_DST_LO  = 10;
    localparam int F_SRC0_HI = 9;
    localparam int F_SRC0_LO = 8;
    localparam int F_SRC1_HI = 7;
    localparam int F_SRC1_LO = 6;
    localparam int F_DATA_HI = 5;
    localparam int F_DATA_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_OUT  = 2'd2
    } seq_state_t;

    // True for opcodes whose result comes back from the ALU.
    function automatic logic is_alu_op(input logic [OPER_W-1:0] oper);
        return (oper != OP_LOAD) && (oper != OP_OUT);
    endfunction

endpackage

// File: rtl/alu_sequencer_regfile.sv
// ----------------------------------------------------------------------------
// seq_regfile
// 4 x 6-bit general register file for the ALU sequencer.
// Ports:
//   i_clk, i_rst_n           clock, synchronous active-low reset (clears all)
//   i_rd0_addr/o_rd0_data    combinational read port 0
//   i_rd1_addr/o_rd1_data    combinational read port 1
//   i_we, i_wr_addr, i_wr_data  synchronous write port
// ----------------------------------------------------------------------------
module seq_regfile
    import alu_sequencer_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_rd0_addr,
    output logic [DATA_W-1:0] o_rd0_data,
    input  logic [ADDR_W-1:0] i_rd1_addr,
    output logic [DATA_W-1:0] o_rd1_data,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data
);

    logic [DATA_W-1:0] r_regs [REG_CNT];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < REG_CNT; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd0_data = r_regs[i_rd0_addr];
    assign o_rd1_data = r_regs[i_rd1_addr];

endmodule

// File: rtl/alu_sequencer.sv
// ----------------------------------------------------------------------------
// alu_sequencer
// Control stage in front of the 6-bit signed ALU. Accepts one 16-bit
// instruction at a time, drives the ALU from registered operands, writes the
// ALU result back into the register file and latches the ALU flags. LOAD
// writes an immediate; OUT emits a register over its own handshake.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds data stable while valid=1 and ready=0; valid
// never depends combinationally on ready.
//
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_instr, i_instr_valid, o_instr_ready   instruction input handshake
//   o_alu_arg0/arg1/oper/data/imm           registered ALU drive
//   i_alu_result, i_alu_flag                ALU combinational results
//   o_flags                   last latched ALU flags
//   o_out_data, o_out_valid, i_out_ready    register output handshake
//   o_instr_cnt               retired instruction count (wraps)
//   o_dbg_state               current FSM state
// ----------------------------------------------------------------------------
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [15:0]        i_instr,
    input  logic               i_instr_valid,
    output logic               o_instr_ready,
    output logic [5:0]         o_alu_arg0,
    output logic [5:0]         o_alu_arg1,
    output logic [2:0]         o_alu_oper,
    output logic [5:0]         o_alu_data,
    output logic               o_alu_imm,
    input  logic [5:0]         i_alu_result,
    input  logic [3:0]         i_alu_flag,
    output logic [3:0]         o_flags,
    output logic [5:0]         o_out_data,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [CNT_W-1:0]   o_instr_cnt,
    output seq_state_t         o_dbg_state
);

    seq_state_t        r_state;
    seq_state_t        w_next_state;

    logic [OPER_W-1:0] w_oper;
    logic              w_imm;
    logic [ADDR_W-1:0] w_dst;
    logic [ADDR_W-1:0] w_src0;
    logic [ADDR_W-1:0] w_src1;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] w_rd0;
    logic [DATA_W-1:0] w_rd1;

    logic              w_accept;
    logic              w_retire;
    logic              w_we;
    logic [DATA_W-1:0] w_wr_data;

    logic [DATA_W-1:0] r_alu_arg0;
    logic [DATA_W-1:0] r_alu_arg1;
    logic [OPER_W-1:0] r_alu_oper;
    logic [DATA_W-1:0] r_alu_data;
    logic              r_alu_imm;
    logic [ADDR_W-1:0] r_dst;
    logic [FLAG_W-1:0] r_flags;
    logic [DATA_W-1:0] r_out_data;
    logic [CNT_W-1:0]  r_cnt;

    assign w_oper = i_instr[F_OPER_HI:F_OPER_LO];
    assign w_imm  = i_instr[F_IMM];
    assign w_dst  = i_instr[F_DST_HI:F_DST_LO];
    assign w_src0 = i_instr[F_SRC0_HI:F_SRC0_LO];
    assign w_src1 = i_instr[F_SRC1_HI:F_SRC1_LO];
    assign w_data = i_instr[F_DATA_HI:F_DATA_LO];

    // Operands are read straight from the incoming instruction's source
    // fields so they can be registered on the accept edge. With only one
    // instruction in flight, the previous writeback has already landed.
    seq_regfile u_regfile (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_rd0_addr (w_src0),
        .o_rd0_data (w_rd0),
        .i_rd1_addr (w_src1),
        .o_rd1_data (w_rd1),
        .i_we       (w_we),
        .i_wr_addr  (r_dst),
        .i_wr_data  (w_wr_data)
    );

    // The registered opcode doubles as the latched instruction's opcode.
    assign w_we      = (r_state == ST_EXEC);
    assign w_wr_data = (r_alu_oper == OP_LOAD) ? r_alu_data : i_alu_result;

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_instr_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = (w_oper == OP_OUT) ? ST_OUT : ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_retire     = 1'b1;
                w_next_state = ST_IDLE;
            end
            ST_OUT: begin
                if (i_out_ready) begin
                    w_retire     = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_alu_arg0 <= '0;
            r_alu_arg1 <= '0;
            r_alu_oper <= '0;
            r_alu_data <= '0;
            r_alu_imm  <= 1'b0;
            r_dst      <= '0;
            r_flags    <= '0;
            r_out_data <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_accept) begin
                r_alu_arg0 <= w_rd0;
                r_alu_arg1 <= w_rd1;
                r_alu_oper <= w_oper;
                r_alu_data <= w_data;
                r_alu_imm  <= w_imm;
                r_dst      <= w_dst;
                if (w_oper == OP_OUT) begin
                    r_out_data <= w_rd0;
                end
            end
            if (w_we && is_alu_op(r_alu_oper)) begin
                r_flags <= i_alu_flag;
            end
            if (w_retire) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_instr_ready = (r_state == ST_IDLE);
    assign o_out_valid   = (r_state == ST_OUT);
    assign o_out_data    = r_out_data;
    assign o_alu_arg0    = r_alu_arg0;
    assign o_alu_arg1    = r_alu_arg1;
    assign o_alu_oper    = r_alu_oper;
    assign o_alu_data    = r_alu_data;
    assign o_alu_imm     = r_alu_imm;
    assign o_flags       = r_flags;
    assign o_instr_cnt   = r_cnt;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic        i_clk;
    logic        i_rst_n;
    logic [15:0] i_instr;
    logic        i_instr_valid;
    logic        o_instr_ready;
    logic [5:0]  o_alu_arg0;
    logic [5:0]  o_alu_arg1;
    logic [2:0]  o_alu_oper;
    logic [5:0]  o_alu_data;
    logic        o_alu_imm;
    logic [5:0]  i_alu_result;
    logic [3:0]  i_alu_flag;
    logic [3:0]  o_flags;
    logic [5:0]  o_out_data;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [7:0]  o_instr_cnt;
    seq_state_t  o_dbg_state;

    alu_sequencer #(.CNT_W(8)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_instr       (i_instr),
        .i_instr_valid (i_instr_valid),
        .o_instr_ready (o_instr_ready),
        .o_alu_arg0    (o_alu_arg0),
        .o_alu_arg1    (o_alu_arg1),
        .o_alu_oper    (o_alu_oper),
        .o_alu_data    (o_alu_data),
        .o_alu_imm     (o_alu_imm),
        .i_alu_result  (i_alu_result),
        .i_alu_flag    (i_alu_flag),
        .o_flags       (o_flags),
        .o_out_data    (o_out_data),
        .o_out_valid   (o_out_valid),
        .i_out_ready   (i_out_ready),
        .o_instr_cnt   (o_instr_cnt),
        .o_dbg_state   (o_dbg_state)
    );

    // ---------------- clock ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- ALU stand-in ----------------
    // Returns {flags[3:0], result[5:0]}. Shift: positive amount shifts left,
    // negative amount shifts right arithmetically.
    function automatic logic [9:0] alu_ref(input logic [2:0] op, input logic [5:0] a,
                                           input logic [5:0] b_reg, input logic imm,
                                           input logic [5:0] d);
        logic [5:0] b;
        logic [5:0] r;
        logic       ovf;
        int         sh;
        b   = imm ? d : b_reg;
        r   = '0;
        ovf = 1'b0;
        case (op)
            3'b000: begin r = a + b; ovf = (a[5] == b[5]) && (r[5] != a[5]); end
            3'b001: begin r = a - b; ovf = (a[5] != b[5]) && (r[5] != a[5]); end
            3'b010: begin
                sh = int'($signed(b));
                if (sh >= 0) r = a << sh;
                else         r = $signed(a) >>> (-sh);
            end
            3'b011: r = a & b;
            3'b100: r = a | b;
            3'b101: r = a ^ b;
            default: r = '0;
        endcase
        return {ovf, (r == 6'd0), (!r[5] && (r != 6'd0)), r[5], r};
    endfunction

    always_comb begin
        {i_alu_flag, i_alu_result} = alu_ref(o_alu_oper, o_alu_arg0, o_alu_arg1, o_alu_imm, o_alu_data);
    end

    // ---------------- scoreboard / model ----------------
    logic [5:0] exp_q[$];
    logic [5:0] m_reg [4];
    logic [3:0] m_flags;
    logic [7:0] m_cnt;
    logic [5:0] e_arg0, e_arg1;
    logic [2:0] e_oper;
    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mk(input logic [2:0] op, input logic imm, input logic [1:0] dst,
                                       input logic [1:0] s0, input logic [1:0] s1, input logic [5:0] d);
        return {op, imm, dst, s0, s1, d};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_reg[i] = '0;
        m_flags = '0;
        m_cnt   = '0;
        exp_q.delete();
    endtask

    task automatic model_apply(input logic [15:0] ins);
        logic [2:0] op;
        logic [9:0] fr;
        op     = ins[15:13];
        e_oper = op;
        e_arg0 = m_reg[ins[9:8]];
        e_arg1 = m_reg[ins[7:6]];
        if (op == OP_OUT) begin
            exp_q.push_back(m_reg[ins[9:8]]);
        end else if (op == OP_LOAD) begin
            m_reg[ins[11:10]] = ins[5:0];
            m_cnt++;
        end else begin
            fr = alu_ref(op, e_arg0, e_arg1, ins[12], ins[5:0]);
            m_reg[ins[11:10]] = fr[5:0];
            m_flags = fr[9:6];
            m_cnt++;
        end
    endtask

    // ---------------- driver tasks ----------------
    // Presents an instruction and returns just after the accepting edge.
    // i_instr_valid is left high; the caller drops it.
    task automatic send(input logic [15:0] ins, output longint acc_t);
        int waited;
        waited = 0;
        @(negedge i_clk);
        i_instr       = ins;
        i_instr_valid = 1'b1;
        while (!o_instr_ready && waited < 20) begin
            @(negedge i_clk);
            waited++;
        end
        if (!o_instr_ready) check_eq("accept_timeout", 32'd0, 32'd1);
        @(posedge i_clk);
        acc_t = $time;
        model_apply(ins);
    endtask

    task automatic exec(input logic [15:0] ins);
        longint t;
        send(ins, t);
        @(negedge i_clk);
        i_instr_valid = 1'b0;
        check_eq("exec_ready", o_instr_ready, 1'b0);
        check_eq("alu_arg0", o_alu_arg0, e_arg0);
        check_eq("alu_arg1", o_alu_arg1, e_arg1);
        check_eq("alu_oper", o_alu_oper, e_oper);
        @(negedge i_clk);
        check_eq("flags", o_flags, m_flags);
        check_eq("instr_cnt", o_instr_cnt, m_cnt);
        check_eq("idle_ready", o_instr_ready, 1'b1);
    endtask

    task automatic do_out(input logic [1:0] src, input int hold);
        longint t;
        logic [5:0] e;
        i_out_ready = 1'b0;
        send(mk(OP_OUT, 1'b0, 2'd0, src, 2'd0, 6'd0), t);
        @(negedge i_clk);
        i_instr_valid = 1'b0;
        e = (exp_q.size() > 0) ? exp_q[0] : 6'd0;
        repeat (hold) begin
            check_eq("out_valid_hold", o_out_valid, 1'b1);
            check_eq("out_data_hold", o_out_data, e);
            check_eq("out_busy", o_instr_ready, 1'b0);
            @(negedge i_clk);
        end
        i_out_ready = 1'b1;
        check_eq("out_valid", o_out_valid, 1'b1);
        if (exp_q.size() == 0) check_eq("sb_empty", 32'd0, 32'd1);
        else check_eq("out_data", o_out_data, exp_q.pop_front());
        @(negedge i_clk);
        i_out_ready = 1'b0;
        m_cnt++;
        check_eq("out_valid_drop", o_out_valid, 1'b0);
        check_eq("out_cnt", o_instr_cnt, m_cnt);
        check_eq("out_done_ready", o_instr_ready, 1'b1);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        model_clear();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        longint t0, t1, t2;
        logic [2:0] op;
        i_rst_n       = 1'b0;
        i_instr       = '0;
        i_instr_valid = 1'b0;
        i_out_ready   = 1'b0;
        model_clear();
        do_reset();

        // Reset state.
        check_eq("rst_ready", o_instr_ready, 1'b1);
        check_eq("rst_flags", o_flags, 4'b0000);
        check_eq("rst_cnt", o_instr_cnt, 8'd0);
        check_eq("rst_out_valid", o_out_valid, 1'b0);
        check_eq("rst_state", o_dbg_state, ST_IDLE);

        // LOAD, LOAD, ADD.
        exec(mk(OP_LOAD, 1'b0, 2'd1, 2'd0, 2'd0, 6'd5));
        exec(mk(OP_LOAD, 1'b0, 2'd2, 2'd0, 2'd0, 6'd7));
        exec(mk(OP_ADD,  1'b0, 2'd3, 2'd1, 2'd2, 6'd0));
        check_eq("add_flags", o_flags, 4'b0010);
        check_eq("add_cnt", o_instr_cnt, 8'd3);

        // Overflow to -32.
        exec(mk(OP_LOAD, 1'b0, 2'd0, 2'd0, 2'd0, 6'd31));
        exec(mk(OP_ADD,  1'b1, 2'd0, 2'd0, 2'd0, 6'd1));
        check_eq("ovf_flags", o_flags, 4'b1001);

        // Zero result, then a LOAD keeps the flags.
        exec(mk(OP_SUB,  1'b0, 2'd1, 2'd1, 2'd1, 6'd0));
        check_eq("sub_flags", o_flags, 4'b0100);
        exec(mk(OP_LOAD, 1'b0, 2'd2, 2'd0, 2'd0, 6'd7));
        check_eq("load_keeps_flags", o_flags, 4'b0100);

        // OUT with stalled consumer.
        do_out(2'd3, 3);
        check_eq("out_r3_data", o_out_data, 6'd12);
        do_out(2'd0, 0);
        do_out(2'd1, 1);

        // Back-to-back valid: accepts every second cycle.
        send(mk(OP_LOAD,  1'b0, 2'd2, 2'd0, 2'd0, 6'd7), t0);
        send(mk(OP_SHIFT, 1'b1, 2'd2, 2'd2, 2'd0, 6'b111110), t1);
        send(mk(OP_LOAD,  1'b0, 2'd1, 2'd0, 2'd0, 6'd9), t2);
        @(negedge i_clk);
        i_instr_valid = 1'b0;
        @(negedge i_clk);
        check_eq("b2b_gap0", 32'(t1 - t0), 32'd20);
        check_eq("b2b_gap1", 32'(t2 - t1), 32'd20);
        check_eq("b2b_cnt", o_instr_cnt, m_cnt);
        do_out(2'd2, 1);
        check_eq("shift_r2", o_out_data, 6'd1);

        // Random mix.
        for (int k = 0; k < 24; k++) begin
            op = 3'($urandom_range(0, 7));
            if (op == OP_OUT) begin
                do_out(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end else begin
                exec(mk(op, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                        2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                        6'($urandom_range(0, 63))));
            end
        end

        // Reset during EXEC of an ADD: no writeback.
        exec(mk(OP_LOAD, 1'b0, 2'd3, 2'd0, 2'd0, 6'd20));
        send(mk(OP_ADD, 1'b1, 2'd3, 2'd3, 2'd3, 6'd5), t0);
        @(negedge i_clk);
        i_instr_valid = 1'b0;
        i_rst_n       = 1'b0;
        @(negedge i_clk);
        check_eq("mrst_ready", o_instr_ready, 1'b1);
        check_eq("mrst_flags", o_flags, 4'b0000);
        check_eq("mrst_cnt", o_instr_cnt, 8'd0);
        check_eq("mrst_arg0", o_alu_arg0, 6'd0);
        check_eq("mrst_arg1", o_alu_arg1, 6'd0);
        check_eq("mrst_oper", o_alu_oper, 3'b000);
        check_eq("mrst_data", o_alu_data, 6'd0);
        check_eq("mrst_imm", o_alu_imm, 1'b0);
        check_eq("mrst_out_data", o_out_data, 6'd0);
        check_eq("mrst_out_valid", o_out_valid, 1'b0);
        check_eq("mrst_state", o_dbg_state, ST_IDLE);
        i_rst_n = 1'b1;
        model_clear();
        do_out(2'd3, 0);

        // Counter wrap: bring count to 255, retire one more.
        while (m_cnt != 8'd255) begin
            exec(mk(OP_LOAD, 1'b0, 2'($urandom_range(0, 3)), 2'd0, 2'd0, 6'($urandom_range(0, 63))));
        end
        check_eq("cnt_255", o_instr_cnt, 8'd255);
        exec(mk(OP_LOAD, 1'b0, 2'd0, 2'd0, 2'd0, 6'd1));
        check_eq("cnt_wrap", o_instr_cnt, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
